// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Requester select encoding is used by both the rr pointer and older flag.
package rf_write_arbiter_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_W  = 4;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } reqSelT;

    function automatic reqSelT otherReq(input reqSelT r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_buffer.sv
// One-entry writeback holding buffer (full bit, destination, data).
// A load on the same edge as a clear wins, so a drained slot can refill at once.
module rf_wb_buffer
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [REG_W-1:0]  loadReg,
    input  logic [DATA_W-1:0] loadData,
    output logic              full,
    output logic [REG_W-1:0]  bufReg,
    output logic [DATA_W-1:0] bufData
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 1'b0;
            bufReg  <= '0;
            bufData <= '0;
        end else if (load) begin
            full    <= 1'b1;
            bufReg  <= loadReg;
            bufData <= loadData;
        end else if (clear) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester writeback arbiter onto a single registered RF write port.
// Optional RF_ARB_R0_ZERO_EN: writes to r0 are accepted but silently dropped.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [REG_W-1:0]  wr_reg,
    output logic [DATA_W-1:0] wr_data,
    input  logic [REG_W-1:0]  q_reg1,
    input  logic [REG_W-1:0]  q_reg2,
    output logic              q_busy1,
    output logic              q_busy2
);

    logic              fullA;
    logic              fullB;
    logic [REG_W-1:0]  regA;
    logic [REG_W-1:0]  regB;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;

    logic   grantA;
    logic   grantB;
    logic   bothFull;
    reqSelT pick;

    logic xferA;
    logic xferB;
    logic loadA;
    logic loadB;
    logic keepA;
    logic keepB;

    reqSelT older;
    reqSelT rr;
    logic   sameEdge;

    rf_wb_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) uBufA (
        .clk      (clk),
        .rst      (rst),
        .load     (loadA),
        .clear    (grantA),
        .loadReg  (a_reg),
        .loadData (a_data),
        .full     (fullA),
        .bufReg   (regA),
        .bufData  (dataA)
    );

    rf_wb_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) uBufB (
        .clk      (clk),
        .rst      (rst),
        .load     (loadB),
        .clear    (grantB),
        .loadReg  (b_reg),
        .loadData (b_data),
        .full     (fullB),
        .bufReg   (regB),
        .bufData  (dataB)
    );

    assign bothFull = fullA & fullB;

    // Age decides unless both entries arrived together, then rr breaks the tie
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        pick   = REQ_A;
        if (bothFull) begin
            pick   = sameEdge ? rr : older;
            grantA = (pick == REQ_A);
            grantB = (pick == REQ_B);
        end else begin
            grantA = fullA;
            grantB = fullB;
        end
    end

    assign a_ready = ~fullA | grantA;
    assign b_ready = ~fullB | grantB;

    assign xferA = a_valid & a_ready;
    assign xferB = b_valid & b_ready;

`ifdef RF_ARB_R0_ZERO_EN
    assign loadA = xferA & (a_reg != '0);
    assign loadB = xferB & (b_reg != '0);
`else
    assign loadA = xferA;
    assign loadB = xferB;
`endif

    assign keepA = fullA & ~grantA;
    assign keepB = fullB & ~grantB;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_reg   <= '0;
            wr_data  <= '0;
            older    <= REQ_A;
            rr       <= REQ_A;
            sameEdge <= 1'b0;
        end else begin
            wr_en <= grantA | grantB;
            unique case (1'b1)
                grantA: begin
                    wr_reg  <= regA;
                    wr_data <= dataA;
                end
                grantB: begin
                    wr_reg  <= regB;
                    wr_data <= dataB;
                end
                default: ;
            endcase
            if (bothFull) begin
                rr <= otherReq(pick);
            end
            // The entry left standing is older than the one just loaded
            if (loadA && loadB) begin
                sameEdge <= 1'b1;
            end else if (loadA && keepB) begin
                older    <= REQ_B;
                sameEdge <= 1'b0;
            end else if (loadB && keepA) begin
                older    <= REQ_A;
                sameEdge <= 1'b0;
            end
        end
    end

    assign q_busy1 = (fullA & (regA == q_reg1))
                   | (fullB & (regB == q_reg1))
                   | (wr_en & (wr_reg == q_reg1));

    assign q_busy2 = (fullA & (regA == q_reg2))
                   | (fullB & (regB == q_reg2))
                   | (wr_en & (wr_reg == q_reg2));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table, corner
// sequences, and a timestamp-ordered reference model under random traffic.
module tb_rf_write_arbiter;

`ifdef RF_ARB_R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic        b_ready;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic [3:0]  q_reg1;
    logic [3:0]  q_reg2;
    logic        q_busy1;
    logic        q_busy2;

    int nCmp = 0;
    int nBad = 0;

    rf_write_arbiter #(.DATA_W(16), .REG_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_reg   (a_reg),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_reg   (b_reg),
        .b_data  (b_data),
        .b_ready (b_ready),
        .wr_en   (wr_en),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .q_reg1  (q_reg1),
        .q_reg2  (q_reg2),
        .q_busy1 (q_busy1),
        .q_busy2 (q_busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rfShadow [16];
    always @(posedge clk) begin
        if (wr_en) rfShadow[wr_reg] <= wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        aV;
        logic [3:0]  aReg;
        logic [15:0] aData;
        logic        bV;
        logic [3:0]  bReg;
        logic [15:0] bData;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        eWr;
        logic [3:0]  eReg;
        logic [15:0] eData;
        logic        eRa;
        logic        eRb;
        logic        eB1;
        logic        eB2;
    } vecT;

    vecT vec [9];

    // Reference model: pending writes carry arrival stamps; oldest wins
    bit          mPend [2];
    logic [3:0]  mReg  [2];
    logic [15:0] mData [2];
    int          mStamp [2];
    int          mRr;
    bit          mWrEn;
    logic [3:0]  mWrReg;
    logic [15:0] mWrData;
    int          cyc;

    function automatic bit mHit(input logic [3:0] q);
        return (mPend[0] && mReg[0] == q) || (mPend[1] && mReg[1] == q)
            || (mWrEn && mWrReg == q);
    endfunction

    task automatic modelReset();
        mPend[0] = 0;
        mPend[1] = 0;
        mReg[0] = '0;
        mReg[1] = '0;
        mData[0] = '0;
        mData[1] = '0;
        mRr = 0;
        mWrEn = 0;
        mWrReg = '0;
        mWrData = '0;
    endtask

    task automatic runModel(input int n, input bit stream, input int rstAt);
        bit holdA = 0;
        bit holdB = 0;
        for (int c = 0; c < n; c++) begin
            int g;
            bit both;
            bit eRa;
            bit eRb;
            bit doRst;
            @(negedge clk);
            doRst = (c == rstAt) || (!stream && $urandom_range(0, 49) == 0);
            rst = doRst;
            if (!holdA) begin
                a_valid = stream || ($urandom_range(0, 9) < 6);
                a_reg = 4'($urandom_range(0, 3));
                a_data = 16'($urandom);
            end
            if (!holdB) begin
                b_valid = stream || ($urandom_range(0, 9) < 6);
                b_reg = 4'($urandom_range(0, 3));
                b_data = 16'($urandom);
            end
            q_reg1 = 4'($urandom_range(0, 3));
            q_reg2 = 4'($urandom_range(0, 3));
            #1;
            both = mPend[0] && mPend[1];
            if (both) begin
                if (mStamp[0] < mStamp[1]) g = 0;
                else if (mStamp[1] < mStamp[0]) g = 1;
                else g = mRr;
            end else if (mPend[0]) g = 0;
            else if (mPend[1]) g = 1;
            else g = -1;
            eRa = !mPend[0] || g == 0;
            eRb = !mPend[1] || g == 1;
            chk("rnd a_ready", 32'(a_ready), 32'(eRa));
            chk("rnd b_ready", 32'(b_ready), 32'(eRb));
            chk("rnd wr_en", 32'(wr_en), 32'(mWrEn));
            chk("rnd wr_reg", 32'(wr_reg), 32'(mWrReg));
            chk("rnd wr_data", 32'(wr_data), 32'(mWrData));
            chk("rnd q_busy1", 32'(q_busy1), 32'(mHit(q_reg1)));
            chk("rnd q_busy2", 32'(q_busy2), 32'(mHit(q_reg2)));
            if (doRst) begin
                modelReset();
            end else begin
                if (g >= 0) begin
                    mWrEn = 1;
                    mWrReg = mReg[g];
                    mWrData = mData[g];
                    mPend[g] = 0;
                    if (both) mRr = 1 - g;
                end else begin
                    mWrEn = 0;
                end
                if (a_valid && eRa && (!R0 || a_reg != 0)) begin
                    mPend[0] = 1;
                    mReg[0] = a_reg;
                    mData[0] = a_data;
                    mStamp[0] = cyc;
                end
                if (b_valid && eRb && (!R0 || b_reg != 0)) begin
                    mPend[1] = 1;
                    mReg[1] = b_reg;
                    mData[1] = b_data;
                    mStamp[1] = cyc;
                end
            end
            holdA = a_valid && !eRa;
            holdB = b_valid && !eRb;
            cyc++;
        end
    endtask

    task automatic idleInputs();
        a_valid = 0;
        a_reg = '0;
        a_data = '0;
        b_valid = 0;
        b_reg = '0;
        b_data = '0;
    endtask

    initial begin
        cyc = 0;
        rst = 1;
        idleInputs();
        q_reg1 = '0;
        q_reg2 = '0;

        vec[0] = '{1, 4'd3, 16'h1234, 0, 4'd0, 16'h0, 4'd3, 4'd0,
                   0, 4'd0, 16'h0000, 1, 1, 0, 0};
        vec[1] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd3, 4'd0,
                   0, 4'd0, 16'h0000, 1, 1, 1, 0};
        vec[2] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd3, 4'd0,
                   1, 4'd3, 16'h1234, 1, 1, 1, 0};
        vec[3] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd3, 4'd0,
                   0, 4'd3, 16'h1234, 1, 1, 0, 0};
        vec[4] = '{1, 4'd5, 16'hAAAA, 1, 4'd5, 16'hBBBB, 4'd5, 4'd5,
                   0, 4'd3, 16'h1234, 1, 1, 0, 0};
        vec[5] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd5, 4'd5,
                   0, 4'd3, 16'h1234, 1, 0, 1, 1};
        vec[6] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd5, 4'd5,
                   1, 4'd5, 16'hAAAA, 1, 1, 1, 1};
        vec[7] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd5, 4'd5,
                   1, 4'd5, 16'hBBBB, 1, 1, 1, 1};
        vec[8] = '{0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 4'd5, 4'd5,
                   0, 4'd5, 16'hBBBB, 1, 1, 0, 0};

        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_reg", 32'(wr_reg), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        chk("reset a_ready", 32'(a_ready), 32'd1);
        chk("reset b_ready", 32'(b_ready), 32'd1);
        chk("reset q_busy1", 32'(q_busy1), 32'd0);
        chk("reset q_busy2", 32'(q_busy2), 32'd0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a_valid = vec[i].aV;
            a_reg = vec[i].aReg;
            a_data = vec[i].aData;
            b_valid = vec[i].bV;
            b_reg = vec[i].bReg;
            b_data = vec[i].bData;
            q_reg1 = vec[i].q1;
            q_reg2 = vec[i].q2;
            #1;
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vec[i].eWr));
            chk($sformatf("vec%0d wr_reg", i), 32'(wr_reg), 32'(vec[i].eReg));
            chk($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vec[i].eData));
            chk($sformatf("vec%0d a_ready", i), 32'(a_ready), 32'(vec[i].eRa));
            chk($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(vec[i].eRb));
            chk($sformatf("vec%0d q_busy1", i), 32'(q_busy1), 32'(vec[i].eB1));
            chk($sformatf("vec%0d q_busy2", i), 32'(q_busy2), 32'(vec[i].eB2));
        end

        // B arrives one edge ahead of A, same destination
        @(negedge clk);
        idleInputs();
        b_valid = 1;
        b_reg = 4'd7;
        b_data = 16'h0007;
        q_reg1 = 4'd7;
        #1;
        chk("age b_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        idleInputs();
        a_valid = 1;
        a_reg = 4'd7;
        a_data = 16'h0070;
        #1;
        chk("age a_ready", 32'(a_ready), 32'd1);
        chk("age busy", 32'(q_busy1), 32'd1);
        chk("age wr_en0", 32'(wr_en), 32'd0);
        @(negedge clk);
        idleInputs();
        #1;
        chk("age first", 32'(wr_data), 32'h0007);
        chk("age first en", 32'(wr_en), 32'd1);
        @(negedge clk);
        #1;
        chk("age second", 32'(wr_data), 32'h0070);
        chk("age second en", 32'(wr_en), 32'd1);
        @(negedge clk);
        #1;
        chk("age idle en", 32'(wr_en), 32'd0);
        chk("age rf r7", 32'(rfShadow[7]), 32'h0070);
        chk("age busy end", 32'(q_busy1), 32'd0);

        // Write to r0
        @(negedge clk);
        a_valid = 1;
        a_reg = 4'd0;
        a_data = 16'h00FF;
        q_reg1 = 4'd0;
        q_reg2 = 4'd0;
        #1;
        chk("r0 a_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        idleInputs();
        #1;
        chk("r0 busy held", 32'(q_busy1), 32'(!R0));
        chk("r0 wr_en0", 32'(wr_en), 32'd0);
        @(negedge clk);
        #1;
        chk("r0 wr_en", 32'(wr_en), 32'(!R0));
        chk("r0 wr_reg", 32'(wr_reg), R0 ? 32'd7 : 32'd0);
        chk("r0 wr_data", 32'(wr_data), R0 ? 32'h0070 : 32'h00FF);
        chk("r0 busy port", 32'(q_busy1), 32'(!R0));
        @(negedge clk);
        #1;
        chk("r0 done", 32'(wr_en), 32'd0);
        chk("r0 busy end", 32'(q_busy2), 32'd0);

        // Resync to a known state, then streaming and random traffic
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        modelReset();
        runModel(60, 1'b1, 30);
        runModel(400, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
